// File: rtl/clock_pkg.sv
// Shared constants for the digital clock timekeeping path.
// Digit limits and digit widths are also used by the seven-segment decoders.
// The helper function hr_at_top tells whether the hours field is at 23 or
// beyond, which is where it wraps to 00.
package clock_pkg;

    localparam int UNITS_W   = 4;   // any units digit, 0-9
    localparam int TENS60_W  = 3;   // tens of seconds or minutes, 0-5
    localparam int HR_TENS_W = 2;   // tens of hours, 0-2

    localparam logic [UNITS_W-1:0]   UNITS_MAX          = 4'd9;
    localparam logic [TENS60_W-1:0]  SEC_TENS_MAX       = 3'd5;
    localparam logic [TENS60_W-1:0]  MIN_TENS_MAX       = 3'd5;
    localparam logic [HR_TENS_W-1:0] HR_MAX_TENS        = 2'd2;
    localparam logic [UNITS_W-1:0]   HR_MAX_ONES_AT_TOP = 4'd3;

    // Out-of-range hours (for example 27 or 3x) count as "at top" so that
    // the next increment returns the field to 00.
    function automatic logic hr_at_top(input logic [HR_TENS_W-1:0] tens,
                                       input logic [UNITS_W-1:0]   ones);
        return (tens > HR_MAX_TENS) ||
               ((tens == HR_MAX_TENS) && (ones >= HR_MAX_ONES_AT_TOP));
    endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD modulo-60 counter used for the seconds and minutes fields.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear, overrides any increment
//   inc          increment without producing a carry (set button)
//   carry_in_en  increment arriving through the carry chain; a wrap from
//                59 to 00 on this path raises carry_out
//   ones, tens   registered BCD digits
//   carry_out    combinational: the field wraps on this edge via the chain
module bcd_mod60_counter
    import clock_pkg::*;
#(
    parameter logic [2:0] TENS_MAX = SEC_TENS_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic       carry_in_en,
    output logic [3:0] ones,
    output logic [2:0] tens,
    output logic       carry_out
);

    logic [3:0] ones_reg;
    logic [2:0] tens_reg;
    logic       advance;
    logic       ones_wrap;
    logic       tens_wrap;

    assign advance   = inc | carry_in_en;
    // ">=" so that an out-of-range digit also rolls back to 0
    assign ones_wrap = (ones_reg >= UNITS_MAX);
    assign tens_wrap = (tens_reg >= TENS_MAX);
    assign carry_out = carry_in_en & ~clr & ones_wrap & tens_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (clr) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (advance) begin
            if (ones_wrap) begin
                ones_reg <= '0;
                tens_reg <= tens_wrap ? 3'd0 : tens_reg + 3'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;

endmodule

// File: rtl/clock_time_counter.sv
// Timekeeping core: divides clk down to a 1 Hz tick and keeps HH:MM:SS as
// six BCD digits, with run/pause, synchronous clear and single-step set
// inputs for minutes and hours.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 1 = prescaler and time advance, 0 = both hold
//   clr                 synchronous clear of digits, prescaler and pulses
//   inc_min, inc_hr     single-cycle set pulses (minutes mod 60, hours mod 24)
//   sec_*/min_*/hr_*    registered BCD digits
//   sec_tick            one cycle, coincident with a new seconds value
//   day_wrap            one cycle, when the tick rolls 23:59:59 -> 00:00:00
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int PRE_W  = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic       sec_tick,
    output logic       day_wrap
);

    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] pre_reg;
    logic             tick;
    logic             tick_adv;
    logic             sec_cout;
    logic             min_cout;
    logic [3:0]       hr_ones_reg;
    logic [1:0]       hr_tens_reg;
    logic             hr_adv;
    logic             hr_top;
    logic             sec_tick_reg;
    logic             day_wrap_reg;

    assign tick = run & (pre_reg >= PRE_TC);

    // A set pulse or a clear on the tick edge swallows that second's advance;
    // the prescaler still wraps, so the next second starts on time.
    assign tick_adv = tick & ~clr & ~inc_min & ~inc_hr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
        end else if (clr) begin
            pre_reg <= '0;
        end else if (run) begin
            pre_reg <= tick ? '0 : pre_reg + PRE_W'(1);
        end
    end

    bcd_mod60_counter #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .inc         (1'b0),
        .carry_in_en (tick_adv),
        .ones        (sec_ones),
        .tens        (sec_tens),
        .carry_out   (sec_cout)
    );

    bcd_mod60_counter #(.TENS_MAX(MIN_TENS_MAX)) u_min (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .inc         (inc_min),
        .carry_in_en (sec_cout),
        .ones        (min_ones),
        .tens        (min_tens),
        .carry_out   (min_cout)
    );

    // Hours: min_cout only occurs on the tick path, so it never coincides
    // with inc_hr; either one advances the field by one hour.
    assign hr_top = hr_at_top(hr_tens_reg, hr_ones_reg);
    assign hr_adv = inc_hr | min_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_ones_reg <= '0;
            hr_tens_reg <= '0;
        end else if (clr) begin
            hr_ones_reg <= '0;
            hr_tens_reg <= '0;
        end else if (hr_adv) begin
            if (hr_top) begin
                hr_ones_reg <= '0;
                hr_tens_reg <= '0;
            end else if (hr_ones_reg >= UNITS_MAX) begin
                hr_ones_reg <= '0;
                hr_tens_reg <= hr_tens_reg + 2'd1;
            end else begin
                hr_ones_reg <= hr_ones_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_tick_reg <= 1'b0;
            day_wrap_reg <= 1'b0;
        end else if (clr) begin
            sec_tick_reg <= 1'b0;
            day_wrap_reg <= 1'b0;
        end else begin
            sec_tick_reg <= tick_adv;
            day_wrap_reg <= min_cout & hr_top;
        end
    end

    assign hr_ones  = hr_ones_reg;
    assign hr_tens  = hr_tens_reg;
    assign sec_tick = sec_tick_reg;
    assign day_wrap = day_wrap_reg;

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

    localparam int CLK_HZ = 4;
    localparam int PRE_W  = 3;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       clr;
    logic       inc_min;
    logic       inc_hr;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic [3:0] hr_ones;
    logic [1:0] hr_tens;
    logic       sec_tick;
    logic       day_wrap;

    clock_time_counter #(.CLK_HZ(CLK_HZ), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .clr      (clr),
        .inc_min  (inc_min),
        .inc_hr   (inc_hr),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .hr_ones  (hr_ones),
        .hr_tens  (hr_tens),
        .sec_tick (sec_tick),
        .day_wrap (day_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int h;
        int m;
        int s;
        bit tick;
        bit wrap;
    } exp_t;

    exp_t expq[$];

    int vectors     = 0;
    int miscompares = 0;
    int wrap_seen   = 0;
    int exp_wraps   = 0;

    // Reference model: time of day as plain h/m/s integers plus a
    // prescaler count; advancing a second is arithmetic on seconds-of-day.
    int m_h, m_m, m_s, m_pre;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_pre = 0;
    endtask

    // One clock of stimulus: drive on the falling edge, predict the state
    // after the following rising edge and queue it for the monitor.
    task automatic step(input bit r, input bit c, input bit im, input bit ih);
        exp_t e;
        bit   tk;
        int   tod;
        @(negedge clk);
        rst_n   = 1'b1;
        run     = r;
        clr     = c;
        inc_min = im;
        inc_hr  = ih;
        e.tick = 1'b0;
        e.wrap = 1'b0;
        if (c) begin
            model_reset();
        end else begin
            tk = r && (m_pre == CLK_HZ - 1);
            if (r) m_pre = (m_pre + 1) % CLK_HZ;
            if (im || ih) begin
                if (im) m_m = (m_m + 1) % 60;
                if (ih) m_h = (m_h + 1) % 24;
            end else if (tk) begin
                tod    = m_h * 3600 + m_m * 60 + m_s + 1;
                e.wrap = (tod == 86400);
                tod    = tod % 86400;
                m_h    = tod / 3600;
                m_m    = (tod / 60) % 60;
                m_s    = tod % 60;
                e.tick = 1'b1;
                if (e.wrap) exp_wraps++;
            end
        end
        e.h = m_h;
        e.m = m_m;
        e.s = m_s;
        expq.push_back(e);
    endtask

    task automatic run_until_sec(input int target);
        for (int i = 0; i < 400 && m_s != target; i++) step(1, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sec_ones"}, int'(sec_ones), 0);
        chk({tag, "_sec_tens"}, int'(sec_tens), 0);
        chk({tag, "_min_ones"}, int'(min_ones), 0);
        chk({tag, "_min_tens"}, int'(min_tens), 0);
        chk({tag, "_hr_ones"},  int'(hr_ones),  0);
        chk({tag, "_hr_tens"},  int'(hr_tens),  0);
        chk({tag, "_sec_tick"}, int'(sec_tick), 0);
        chk({tag, "_day_wrap"}, int'(day_wrap), 0);
    endtask

    // Asynchronous reset pulse between edges: outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
    endtask

    // Monitor: after every rising edge, pop the prediction for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("sec_ones", int'(sec_ones), e.s % 10);
                chk("sec_tens", int'(sec_tens), e.s / 10);
                chk("min_ones", int'(min_ones), e.m % 10);
                chk("min_tens", int'(min_tens), e.m / 10);
                chk("hr_ones",  int'(hr_ones),  e.h % 10);
                chk("hr_tens",  int'(hr_tens),  e.h / 10);
                chk("sec_tick", int'(sec_tick), int'(e.tick));
                chk("day_wrap", int'(day_wrap), int'(e.wrap));
                if (day_wrap) wrap_seen++;
                if (sec_tick)
                    $display("tick @%0t: %0d%0d:%0d%0d:%0d%0d day_wrap=%0d", $time,
                             hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones, day_wrap);
            end
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; clr = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");

        // 1: free run from reset
        repeat (40) step(1, 0, 0, 0);

        // 2: set 23:59:58 and roll over the day
        step(0, 1, 0, 0);
        repeat (23) step(0, 0, 0, 1);
        repeat (59) step(0, 0, 1, 0);
        run_until_sec(58);
        repeat (2 * CLK_HZ) step(1, 0, 0, 0);

        // 3: pause with a partial second pending
        for (int i = 0; i < 8 && m_pre != 2; i++) step(1, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);

        // 4: inc_min wrap at 00:59:30, inc_hr wrap at 23:xx:xx
        step(0, 1, 0, 0);
        run_until_sec(30);
        repeat (59) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        repeat (23) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);

        // 5: inc_min on the terminal edge at 00:10:05 drops that tick
        step(0, 1, 0, 0);
        repeat (10) step(0, 0, 1, 0);
        run_until_sec(5);
        for (int i = 0; i < 8 && m_pre != CLK_HZ - 1; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        run_until_sec(6);

        // 6: clr with inc_hr mid-count, then an async reset pulse
        repeat (6) step(1, 0, 0, 1);
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        repeat (7) step(1, 0, 0, 0);
        async_reset();
        repeat (6) step(1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99, 0) < 85,
                 $urandom_range(99, 0) < 2,
                 $urandom_range(99, 0) < 6,
                 $urandom_range(99, 0) < 6);
        end

        // Drain the scoreboard within a bounded number of edges
        for (int i = 0; i < 4 && expq.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        chk("queue_drained", expq.size(), 0);
        chk("day_wrap_count", wrap_seen, exp_wraps);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
